// File: rtl/mezclador_bandas.sv
// Three-band mixer: weights low/mid/high band samples by per-band gains using one
// shared multiplier over four cycles, then clips the sum to the output word.
module mezclador_bandas #(
  parameter int size = 21,
  parameter int sign = 1,
  parameter int mag  = 5,
  parameter int pf   = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   EN,
  input  logic signed [size-1:0] y1,
  input  logic signed [size-1:0] y2,
  input  logic signed [size-1:0] y3,
  input  logic signed [size-1:0] g1,
  input  logic signed [size-1:0] g2,
  input  logic signed [size-1:0] g3,
  output logic signed [size-1:0] y,
  output logic                   done,
  output logic                   sat,
  output logic                   ovr
);

  localparam int ACC_W = 2*size - pf + 2;
  localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-size+1){1'b0}}, {(size-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MIN_V = {{(ACC_W-size+1){1'b1}}, {(size-1){1'b0}}};

  if (sign + mag + pf != size) begin : g_fmt_check
    $error("mezclador_bandas: sign + mag + pf must equal size");
  end

  typedef enum logic [2:0] {IDLE, MAC1, MAC2, MAC3, SAT} state_t;

  state_t state, state_n;

  logic signed [size-1:0]   y1_p0, y2_p0, y3_p0, g1_p0, g2_p0, g3_p0;
  logic signed [ACC_W-1:0]  acc_p1;
  logic signed [size-1:0]   op_y, op_g;
  logic signed [2*size-1:0] prod;
  logic signed [ACC_W-1:0]  term;

  function automatic logic signed [size-1:0] clip(input logic signed [ACC_W-1:0] a);
    if (a > MAX_V)      return MAX_V[size-1:0];
    else if (a < MIN_V) return MIN_V[size-1:0];
    else                return a[size-1:0];
  endfunction

  function automatic logic clipped(input logic signed [ACC_W-1:0] a);
    return (a > MAX_V) || (a < MIN_V);
  endfunction

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (EN) state_n = MAC1;
      MAC1:    state_n = MAC2;
      MAC2:    state_n = MAC3;
      MAC3:    state_n = SAT;
      SAT:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Operand select for the shared multiplier; the product is floored to the gain scale.
  always_comb begin
    op_y = '0;
    op_g = '0;
    case (state)
      MAC1: begin op_y = y1_p0; op_g = g1_p0; end
      MAC2: begin op_y = y2_p0; op_g = g2_p0; end
      MAC3: begin op_y = y3_p0; op_g = g3_p0; end
      default: ;
    endcase
  end

  assign prod = (2*size)'(op_y) * (2*size)'(op_g);
  assign term = ACC_W'(prod >>> pf);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Stage p0: capture band samples and gains on the strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y1_p0 <= '0; y2_p0 <= '0; y3_p0 <= '0;
      g1_p0 <= '0; g2_p0 <= '0; g3_p0 <= '0;
    end else if (state == IDLE && EN) begin
      y1_p0 <= y1; y2_p0 <= y2; y3_p0 <= y3;
      g1_p0 <= g1; g2_p0 <= g2; g3_p0 <= g3;
    end
  end

  // Stage p1: accumulate one band product per MAC state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_p1 <= '0;
    end else if (state == IDLE && EN) begin
      acc_p1 <= '0;
    end else if (state == MAC1 || state == MAC2 || state == MAC3) begin
      acc_p1 <= acc_p1 + term;
    end
  end

  // Output stage: clip, publish and flag; strobes during a sample latch the overrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y    <= '0;
      done <= 1'b0;
      sat  <= 1'b0;
      ovr  <= 1'b0;
    end else begin
      done <= (state == SAT);
      sat  <= (state == SAT) && clipped(acc_p1);
      if (state == SAT) y <= clip(acc_p1);
      if (EN && state != IDLE) ovr <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mezclador_bandas.sv
// Directed bench for mezclador_bandas: table of mix vectors plus overrun and reset sequences.
module tb_mezclador_bandas;

  localparam int W = 21;

  logic                clk, rst, EN;
  logic signed [W-1:0] y1, y2, y3, g1, g2, g3;
  logic signed [W-1:0] y;
  logic                done, sat, ovr;

  int tests = 0;
  int fails = 0;

  mezclador_bandas dut (
    .clk(clk), .rst(rst), .EN(EN),
    .y1(y1), .y2(y2), .y3(y3),
    .g1(g1), .g2(g2), .g3(g3),
    .y(y), .done(done), .sat(sat), .ovr(ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [W-1:0] y1, y2, y3, g1, g2, g3;
    logic [W-1:0] ey;
    logic         esat;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic set_inputs(input vec_t v);
    y1 = v.y1; y2 = v.y2; y3 = v.y3;
    g1 = v.g1; g2 = v.g2; g3 = v.g3;
  endtask

  // Pulse EN for one edge, then expect done exactly four edges later.
  task automatic run_sample(input vec_t v, input logic exp_ovr);
    int n;
    logic [W-1:0] held;
    @(negedge clk);
    set_inputs(v);
    EN = 1'b1;
    @(negedge clk);
    EN = 1'b0;
    n = 0;
    while (n < 10) begin
      @(negedge clk);
      n++;
      if (done) break;
    end
    chk({v.name, "_latency"}, W'(n), W'(4));
    chk({v.name, "_done"}, W'(done), W'(1));
    chk({v.name, "_y"}, y, v.ey);
    chk({v.name, "_sat"}, W'(sat), W'(v.esat));
    chk({v.name, "_ovr"}, W'(ovr), W'(exp_ovr));
    held = y;
    @(negedge clk);
    chk({v.name, "_done_low"}, W'(done), W'(0));
    chk({v.name, "_sat_low"}, W'(sat), W'(0));
    chk({v.name, "_y_hold"}, y, held);
  endtask

  initial begin
    int seen;
    vec_t vb;

    vecs[0] = '{"unity",     21'h001000, 21'h002000, 21'h003000, 21'h008000, 21'h008000, 21'h008000, 21'h006000, 1'b0};
    vecs[1] = '{"clip_pos",  21'h0F0000, 21'h0F0000, 21'h0F0000, 21'h008000, 21'h008000, 21'h008000, 21'h0FFFFF, 1'b1};
    vecs[2] = '{"clip_neg",  21'h100000, 21'h100000, 21'h100000, 21'h008000, 21'h008000, 21'h008000, 21'h100000, 1'b1};
    vecs[3] = '{"trunc_pos", 21'h000003, 21'h000000, 21'h000000, 21'h004000, 21'h000000, 21'h000000, 21'h000001, 1'b0};
    vecs[4] = '{"trunc_neg", 21'h1FFFFD, 21'h000000, 21'h000000, 21'h004000, 21'h000000, 21'h000000, 21'h1FFFFE, 1'b0};
    vecs[5] = '{"mixed",     21'h000800, 21'h000400, 21'h000100, 21'h010000, 21'h1F8000, 21'h004000, 21'h000C80, 1'b0};
    vecs[6] = '{"exact_max", 21'h0FFFFF, 21'h000000, 21'h000000, 21'h008000, 21'h000000, 21'h000000, 21'h0FFFFF, 1'b0};
    vecs[7] = '{"just_over", 21'h0FFFFF, 21'h000001, 21'h000000, 21'h008000, 21'h008000, 21'h000000, 21'h0FFFFF, 1'b1};

    rst = 1'b1; EN = 1'b0;
    y1 = '0; y2 = '0; y3 = '0; g1 = '0; g2 = '0; g3 = '0;

    // Reset with EN toggling.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      EN = ~EN;
      set_inputs(vecs[0]);
    end
    @(negedge clk);
    EN = 1'b0;
    chk("rst_y", y, '0);
    chk("rst_done", W'(done), W'(0));
    chk("rst_sat", W'(sat), W'(0));
    chk("rst_ovr", W'(ovr), W'(0));
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk("idle_no_done", W'(seen), W'(0));
    chk("idle_y", y, '0);
    chk("idle_ovr", W'(ovr), W'(0));

    for (int i = 0; i < 8; i++) run_sample(vecs[i], 1'b0);

    // Overrun: second strobe two cycles in, inputs changed in between.
    vb = vecs[5];
    @(negedge clk);
    set_inputs(vecs[0]);
    EN = 1'b1;
    @(negedge clk);
    EN = 1'b0;
    set_inputs(vb);
    chk("ovr_c0_done", W'(done), W'(0));
    @(negedge clk);
    EN = 1'b1;
    chk("ovr_c1_ovr", W'(ovr), W'(0));
    @(negedge clk);
    EN = 1'b0;
    @(negedge clk);
    chk("ovr_c3_ovr", W'(ovr), W'(1));
    chk("ovr_c3_done", W'(done), W'(0));
    @(negedge clk);
    chk("ovr_c4_done", W'(done), W'(1));
    chk("ovr_c4_y", y, 21'h006000);
    chk("ovr_c4_sat", W'(sat), W'(0));
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk("ovr_single_done", W'(seen), W'(0));
    chk("ovr_sticky", W'(ovr), W'(1));
    run_sample(vecs[3], 1'b1);
    chk("ovr_still_set", W'(ovr), W'(1));

    // Reset during MAC2 aborts the sample.
    @(negedge clk);
    set_inputs(vecs[1]);
    EN = 1'b1;
    @(negedge clk);
    EN = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_y", y, '0);
    chk("midrst_ovr", W'(ovr), W'(0));
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk("midrst_no_done", W'(seen), W'(0));
    chk("midrst_y_after", y, '0);
    run_sample(vecs[0], 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, tests=%0d", tests);
    $fatal(1, "timeout");
  end

endmodule
